prt_frame_tx: RTL

Drain-side master of the packet reference table (PRT). It accepts a forward/drop verdict per PRT slot, reads the frame out of the PRT and streams it to the MAC TX path with a valid/ready/last byte stream, then invalidates the slot. The PRT read port cannot stall, so backpressure is absorbed by a small output FIFO; when the FIFO runs out of room, the block restarts the slot read and skips the bytes already captured (replay).

---
 rtl/prt_pkg.sv | 18 +
 rtl/prt_tx_fifo.sv | 52 +++++
 rtl/prt_frame_tx.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/prt_pkg.sv
// Shared types and constants for the packet reference table (PRT) drain-side blocks.
package prt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_RD,
        ST_WAIT_RD,
        ST_SKIP,
        ST_STREAM,
        ST_PAUSE,
        ST_INVAL
    } prt_tx_state_t;

    localparam int unsigned PRT_FLAG_BIT  = 0;
    localparam int unsigned PRT_NUM_SLOTS = 2;
    localparam int unsigned PRT_SLOT_W    = $clog2(PRT_NUM_SLOTS);

endpackage

// File: rtl/prt_tx_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is accepted only with a same-cycle pop.
module prt_tx_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != FULL_LVL) || do_pop);
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/prt_frame_tx.sv
// Drains PRT slots to the MAC TX byte stream; backpressure beyond the FIFO is handled by
// restarting the slot read and skipping bytes already captured.
module prt_frame_tx
    import prt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  tx_req_valid,
    input  logic                  tx_req_slot,
    input  logic                  tx_req_drop,
    output logic                  tx_req_ready,
    output logic                  prt_start_rd_en,
    output logic                  prt_start_rd_slot,
    input  logic                  prt_start_rd_rdy,
    output logic                  prt_rd_en,
    input  logic [DATA_WIDTH:0]   prt_rd_data,
    input  logic                  prt_rd_rdy,
    output logic                  prt_inval_en,
    output logic                  prt_inval_slot,
    input  logic                  prt_inval_rdy,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_last,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  stat_frames_tx,
    output logic [CNT_WIDTH-1:0]  stat_frames_drop,
    output logic [CNT_WIDTH-1:0]  stat_replays
);

    localparam int unsigned        FCW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FCW-1:0]     FIFO_FULL = FCW'(FIFO_DEPTH);
    localparam logic [FCW-1:0]     FIFO_HALF = FCW'(FIFO_DEPTH / 2);

    prt_tx_state_t             state_q, state_d;
    logic [PRT_SLOT_W-1:0]     slot_q, slot_d;
    logic                      tx_path_q, tx_path_d;
    logic [CNT_WIDTH-1:0]      idx_q, idx_d;
    logic [CNT_WIDTH-1:0]      skip_q, skip_d;
    logic                      stg_valid_q, stg_valid_d;
    logic [DATA_WIDTH-1:0]     stg_data_q, stg_data_d;
    logic [CNT_WIDTH-1:0]      st_tx_q, st_tx_d;
    logic [CNT_WIDTH-1:0]      st_drop_q, st_drop_d;
    logic [CNT_WIDTH-1:0]      st_rep_q, st_rep_d;

    logic                      fifo_push;
    logic [DATA_WIDTH:0]       fifo_wdata;
    logic [DATA_WIDTH:0]       fifo_rdata;
    logic                      fifo_empty;
    logic [FCW-1:0]            fifo_count;
    logic                      pop;
    logic                      room;
    logic                      entry_end;
    logic [DATA_WIDTH-1:0]     entry_data;

    prt_tx_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_valid          = !fifo_empty;
    assign tx_last           = fifo_rdata[DATA_WIDTH];
    assign tx_data           = fifo_rdata[DATA_WIDTH-1:0];
    assign pop               = tx_valid && tx_ready;
    assign entry_end         = prt_rd_data[PRT_FLAG_BIT];
    assign entry_data        = prt_rd_data[DATA_WIDTH:1];
    // A new entry only needs FIFO space if a staged byte must be pushed out to make way for it.
    assign room              = !stg_valid_q || (fifo_count < FIFO_FULL) || pop;
    assign tx_req_ready      = (state_q == ST_IDLE);
    assign busy              = (state_q != ST_IDLE);
    assign prt_start_rd_slot = slot_q;
    assign prt_inval_slot    = slot_q;
    assign stat_frames_tx    = st_tx_q;
    assign stat_frames_drop  = st_drop_q;
    assign stat_replays      = st_rep_q;

    always_comb begin
        state_d         = state_q;
        slot_d          = slot_q;
        tx_path_d       = tx_path_q;
        idx_d           = idx_q;
        skip_d          = skip_q;
        stg_valid_d     = stg_valid_q;
        stg_data_d      = stg_data_q;
        st_tx_d         = st_tx_q;
        st_drop_d       = st_drop_q;
        st_rep_d        = st_rep_q;
        prt_start_rd_en = 1'b0;
        prt_rd_en       = 1'b0;
        prt_inval_en    = 1'b0;
        fifo_push       = 1'b0;
        fifo_wdata      = {1'b0, stg_data_q};

        case (state_q)
            ST_IDLE: begin
                if (tx_req_valid) begin
                    slot_d      = tx_req_slot;
                    idx_d       = '0;
                    skip_d      = '0;
                    stg_valid_d = 1'b0;
                    tx_path_d   = 1'b0;
                    state_d     = tx_req_drop ? ST_INVAL : ST_START_RD;
                end
            end
            ST_START_RD: begin
                if (prt_start_rd_rdy) begin
                    prt_start_rd_en = 1'b1;
                    state_d         = ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (prt_rd_rdy) begin
                    state_d = (skip_q != '0) ? ST_SKIP : ST_STREAM;
                end
            end
            ST_SKIP: begin
                if (prt_rd_rdy) begin
                    prt_rd_en = 1'b1;
                    skip_d    = skip_q - 1'b1;
                    if (skip_q == CNT_WIDTH'(1)) begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (!room) begin
                    state_d = ST_PAUSE;
                end else if (prt_rd_rdy) begin
                    prt_rd_en = 1'b1;
                    if (!entry_end) begin
                        fifo_push   = stg_valid_q;
                        stg_data_d  = entry_data;
                        stg_valid_d = 1'b1;
                        idx_d       = idx_q + 1'b1;
                    end else begin
                        // The byte is held back one entry so the end flag can mark it last.
                        fifo_push   = stg_valid_q;
                        fifo_wdata  = {1'b1, stg_data_q};
                        tx_path_d   = stg_valid_q;
                        stg_valid_d = 1'b0;
                        state_d     = ST_INVAL;
                    end
                end
            end
            ST_PAUSE: begin
                if (fifo_count <= FIFO_HALF) begin
                    skip_d   = idx_q;
                    st_rep_d = st_rep_q + 1'b1;
                    state_d  = ST_START_RD;
                end
            end
            ST_INVAL: begin
                if (prt_inval_rdy) begin
                    prt_inval_en = 1'b1;
                    if (tx_path_q) begin
                        st_tx_d = st_tx_q + 1'b1;
                    end else begin
                        st_drop_d = st_drop_q + 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            tx_path_q   <= 1'b0;
            idx_q       <= '0;
            skip_q      <= '0;
            stg_valid_q <= 1'b0;
            stg_data_q  <= '0;
            st_tx_q     <= '0;
            st_drop_q   <= '0;
            st_rep_q    <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            tx_path_q   <= tx_path_d;
            idx_q       <= idx_d;
            skip_q      <= skip_d;
            stg_valid_q <= stg_valid_d;
            stg_data_q  <= stg_data_d;
            st_tx_q     <= st_tx_d;
            st_drop_q   <= st_drop_d;
            st_rep_q    <= st_rep_d;
        end
    end

endmodule
